// File: rtl/datamover_tcdm_responder.sv
// TCDM target model for the datamover streamer: word-interleaved 32-bit memory,
// one wide request per cycle, 1-cycle read latency, LFSR-driven grant stalls.
module datamover_tcdm_responder #(
    parameter int unsigned DW        = 288,
    parameter int unsigned AW        = 32,
    parameter int unsigned N_WORDS   = 1024,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [3:0]        stall_thr_i,
    input  logic              tcdm_req_i,
    output logic              tcdm_gnt_o,
    input  logic [AW-1:0]     tcdm_add_i,
    input  logic              tcdm_wen_i,
    input  logic [DW/8-1:0]   tcdm_be_i,
    input  logic [DW-1:0]     tcdm_data_i,
    output logic [DW-1:0]     tcdm_r_data_o,
    output logic              tcdm_r_valid_o,
    input  logic              tcdm_r_ready_i,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
);

    localparam int unsigned NL    = DW / 32;
    localparam int unsigned IDX_W = $clog2(N_WORDS);

    if ((DW % 32) != 0 || N_WORDS < NL || (N_WORDS & (N_WORDS - 1)) != 0 ||
        LFSR_SEED == 16'h0000) begin : g_bad_params
        $error("datamover_tcdm_responder: illegal parameter set");
    end

    logic [15:0]      lfsr_q;
    logic             stall;
    logic             resp_hold;
    logic             gnt_p0;
    logic             rd_gnt_p0;
    logic             wr_gnt_p0;
    logic [IDX_W-1:0] w0_p0;
    logic [IDX_W-1:0] lane_idx_p0 [NL];
    logic [DW-1:0]    rd_word_p0;
    logic [31:0]      mem_q [N_WORDS];
    logic             vld_p1;
    logic [DW-1:0]    rdata_p1;
    logic [31:0]      rd_cnt_q;
    logic [31:0]      wr_cnt_q;
    logic             unused_add;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // p0: request stage -- grant decision, lane address generation, array read
    assign stall      = (lfsr_q[3:0] < stall_thr_i);
    assign resp_hold  = vld_p1 & ~tcdm_r_ready_i;
    assign gnt_p0     = tcdm_req_i & ~stall & ~resp_hold;
    assign rd_gnt_p0  = gnt_p0 & tcdm_wen_i;
    assign wr_gnt_p0  = gnt_p0 & ~tcdm_wen_i;
    assign tcdm_gnt_o = gnt_p0;

    // Only the word index within the array matters; byte offset and high bits are dropped.
    assign w0_p0      = tcdm_add_i[2 +: IDX_W];
    assign unused_add = ^{tcdm_add_i[AW-1:2+IDX_W], tcdm_add_i[1:0]};

    always_comb begin
        for (int k = 0; k < NL; k++) begin
            lane_idx_p0[k]            = w0_p0 + IDX_W'(k);
            rd_word_p0[32*k +: 32]    = mem_q[lane_idx_p0[k]];
        end
    end

    // Memory is intentionally not reset; writes land even on a clearing cycle.
    always_ff @(posedge clk_i) begin
        if (wr_gnt_p0) begin
            for (int k = 0; k < NL; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (tcdm_be_i[4*k+b]) begin
                        mem_q[lane_idx_p0[k]][8*b +: 8] <= tcdm_data_i[32*k+8*b +: 8];
                    end
                end
            end
        end
    end

    // p1: response stage -- held under back-pressure, refilled on a new read grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q   <= LFSR_SEED;
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (clear_i) begin
            lfsr_q   <= LFSR_SEED;
            vld_p1   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            if (rd_gnt_p0) begin
                vld_p1   <= 1'b1;
                rdata_p1 <= rd_word_p0;
            end else if (tcdm_r_ready_i) begin
                vld_p1 <= 1'b0;
            end
            if (rd_gnt_p0) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (wr_gnt_p0) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign tcdm_r_valid_o = vld_p1;
    assign tcdm_r_data_o  = rdata_p1;
    assign rd_cnt_o       = rd_cnt_q;
    assign wr_cnt_o       = wr_cnt_q;

endmodule
